// File: rtl/fpu_ctrl_pkg.sv
// Shared types for the FPU issue controller slice.
//   fpu_op_e    : operation codes presented to the FPU core
//   fpu_flags_t : core status flags, MSB first {inf..div_by_zero}
//   pipe_ent_t  : in-flight tracking entry {valid, id, tag}
package fpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    DIV = 3'd3,
    I2F = 3'd4,
    F2I = 3'd5
  } fpu_op_e;

  typedef struct packed {
    logic inf;
    logic snan;
    logic qnan;
    logic ine;
    logic overflow;
    logic underflow;
    logic zero;
    logic div_by_zero;
  } fpu_flags_t;

  // Tag field is sized for the widest requester tag the slice supports;
  // users with TAG_W <= PIPE_TAG_W keep their tag in the low bits.
  localparam int unsigned PIPE_TAG_W = 16;

  typedef struct packed {
    logic                  valid;
    logic                  id;
    logic [PIPE_TAG_W-1:0] tag;
  } pipe_ent_t;

endpackage

// File: rtl/fpu_rsp_fifo.sv
// Synchronous response FIFO, no fall-through.
//   clk, rst      : clock, synchronous active-high reset (flushes contents)
//   push, wdata   : write request and data
//   pop, rdata    : read request and head data (zero while empty)
//   count         : current occupancy
//   empty, full   : occupancy status
module fpu_rsp_fifo
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 45
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Shares one fixed-latency FPU core between two requesters.
//   clk, rst                  : clock, synchronous active-high reset
//   reqN_valid/ready          : request handshake, N = 0,1
//   reqN_op/rmode/opa/opb/tag : request fields
//   fpu_op, rmode, opa, opb   : registered core inputs
//   fpu_res, fpu_flags        : core outputs, valid LAT cycles after inputs
//   rsp_valid/ready           : response handshake
//   rsp_out/flags/id/tag      : response FIFO head
module fpu_issue_ctrl #(
  parameter int unsigned LAT   = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [1:0]       req0_rmode,
  input  logic [31:0]      req0_opa,
  input  logic [31:0]      req0_opb,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [1:0]       req1_rmode,
  input  logic [31:0]      req1_opa,
  input  logic [31:0]      req1_opb,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [2:0]       fpu_op,
  output logic [1:0]       rmode,
  output logic [31:0]      opa,
  output logic [31:0]      opb,
  input  logic [31:0]      fpu_res,
  input  logic [7:0]       fpu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_out,
  output logic [7:0]       rsp_flags,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag
);

  import fpu_ctrl_pkg::*;

  localparam int unsigned FCW = $clog2(DEPTH+1);
  localparam int unsigned CW  = $clog2(DEPTH+LAT+2);
  localparam int unsigned RW  = 32 + 8 + 1 + TAG_W;

  pipe_ent_t [LAT:0]  pipe_q;
  pipe_ent_t          new_ent;
  logic               last_grant_q;
  logic [CW-1:0]      inflight;
  logic [FCW-1:0]     fcount;
  logic               issue_ok;
  logic               accept0;
  logic               accept1;
  logic               fifo_empty;
  logic               unused_fifo_full;
  logic [PIPE_TAG_W-1:0] unused_tag_hi;
  logic [RW-1:0]      fifo_wdata;
  logic [RW-1:0]      fifo_rdata;
  fpu_flags_t         core_flags;

  // Every op counts against the credit limit from accept until its response
  // pops, so the FIFO always has room when the core result lands.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i <= LAT; i++) begin
      inflight = inflight + CW'(pipe_q[i].valid);
    end
  end

  assign issue_ok = !rst && ((inflight + CW'(fcount)) < CW'(DEPTH));

  // last_grant_q = 1 means req1 won most recently, so req0 wins a tie.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (issue_ok) begin
      if (req0_valid && req1_valid) begin
        req0_ready = last_grant_q;
        req1_ready = !last_grant_q;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  assign accept0 = req0_valid && req0_ready;
  assign accept1 = req1_valid && req1_ready;

  always_comb begin
    new_ent       = '0;
    new_ent.valid = accept0 || accept1;
    new_ent.id    = accept1;
    new_ent.tag   = PIPE_TAG_W'(accept1 ? req1_tag : req0_tag);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      fpu_op       <= '0;
      rmode        <= '0;
      opa          <= '0;
      opb          <= '0;
    end else if (accept0) begin
      last_grant_q <= 1'b0;
      fpu_op       <= req0_op;
      rmode        <= req0_rmode;
      opa          <= req0_opa;
      opb          <= req0_opb;
    end else if (accept1) begin
      last_grant_q <= 1'b1;
      fpu_op       <= req1_op;
      rmode        <= req1_rmode;
      opa          <= req1_opa;
      opb          <= req1_opb;
    end
  end

  // Stage LAT lines up with the cycle the core result is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= {pipe_q[LAT-1:0], new_ent};
    end
  end

  assign core_flags    = fpu_flags;
  assign fifo_wdata    = {fpu_res, core_flags, pipe_q[LAT].id, pipe_q[LAT].tag[TAG_W-1:0]};
  assign unused_tag_hi = pipe_q[LAT].tag >> TAG_W;

  fpu_rsp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RW)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pipe_q[LAT].valid),
    .wdata (fifo_wdata),
    .pop   (rsp_valid && rsp_ready),
    .rdata (fifo_rdata),
    .count (fcount),
    .empty (fifo_empty),
    .full  (unused_fifo_full)
  );

  assign rsp_valid = !fifo_empty;
  assign {rsp_out, rsp_flags, rsp_id, rsp_tag} = fifo_rdata;

endmodule
